// File: rtl/ro_freq_comparator.sv
// Ring-oscillator frequency comparator: counts synchronised rising edges of two
// selected ROs over a fixed gate window and emits one PUF response bit per run.
`timescale 1ns/1ps
module ro_freq_comparator #(
    parameter int NUM_RO = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        ro1_sel,
    input  logic [2:0]        ro2_sel,
    input  logic [NUM_RO-1:0] ro_out,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic              tie,
    output logic              sel_err,
    output logic [CNT_W-1:0]  count1,
    output logic [CNT_W-1:0]  count2
);
    localparam int               TMR_W       = 21;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    logic [NUM_RO-1:0] s1_q, s2_q, s3_q;
    logic [NUM_RO-1:0] ro_edge_s;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             response_q, response_d, tie_q, tie_d, sel_err_q, sel_err_d;
    logic [CNT_W-1:0] count1_q, count1_d, count2_q, count2_d;

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Three-flop synchronisers on every raw RO net.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_q <= {NUM_RO{1'b0}};
            s2_q <= {NUM_RO{1'b0}};
            s3_q <= {NUM_RO{1'b0}};
        end else begin
            s1_q <= ro_out;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign ro_edge_s = s2_q & ~s3_q;

    // Control and datapath state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= {TMR_W{1'b0}};
            sel1_q     <= 3'd0;
            sel2_q     <= 3'd0;
            cnt1_q     <= {CNT_W{1'b0}};
            cnt2_q     <= {CNT_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            response_q <= 1'b0;
            tie_q      <= 1'b0;
            sel_err_q  <= 1'b0;
            count1_q   <= {CNT_W{1'b0}};
            count2_q   <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            response_q <= response_d;
            tie_q      <= tie_d;
            sel_err_q  <= sel_err_d;
            count1_q   <= count1_d;
            count2_q   <= count2_d;
        end
    end

    // Next-state logic; the DONE state computes results that appear one cycle
    // later, so start is also blocked while the done pulse is visible.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        response_d = response_q;
        tie_d      = tie_q;
        sel_err_d  = sel_err_q;
        count1_d   = count1_q;
        count2_d   = count2_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d    = ST_SETTLE;
                    timer_d    = {TMR_W{1'b0}};
                    sel1_d     = ro1_sel;
                    sel2_d     = ro2_sel;
                    cnt1_d     = {CNT_W{1'b0}};
                    cnt2_d     = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                    response_d = 1'b0;
                    tie_d      = 1'b0;
                    sel_err_d  = (ro1_sel == ro2_sel);
                    count1_d   = {CNT_W{1'b0}};
                    count2_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_COUNT;
                    timer_d = {TMR_W{1'b0}};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_COUNT: begin
                cnt1_d = sat_inc(cnt1_q, ro_edge_s[sel1_q]);
                cnt2_d = sat_inc(cnt2_q, ro_edge_s[sel2_q]);
                if (timer_q == WINDOW_LAST) begin
                    state_d = ST_DONE;
                    timer_d = {TMR_W{1'b0}};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                response_d = (cnt1_q > cnt2_q) && !sel_err_q;
                tie_d      = (cnt1_q == cnt2_q);
                count1_d   = cnt1_q;
                count2_d   = cnt2_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign response = response_q;
    assign tie      = tie_q;
    assign sel_err  = sel_err_q;
    assign count1   = count1_q;
    assign count2   = count2_q;
endmodule

// File: tb/tb_ro_freq_comparator.sv
// Self-checking bench for ro_freq_comparator: two instances (wide counters with a
// short window, and narrow counters for saturation) driven by a simulated RO bank.
`timescale 1ns/1ps
module tb_ro_freq_comparator;
    localparam int NRO   = 8;
    localparam int SET   = 4;
    localparam int WIN_A = 48;
    localparam int WIN_B = 200;
    localparam int CW_A  = 16;
    localparam int CW_B  = 4;

    logic clk = 1'b0;
    logic reset_n, start_a, start_b;
    logic [2:0] ro1_sel, ro2_sel;
    logic [NRO-1:0] ro_out;
    logic busy_a, done_a, resp_a, tie_a, serr_a;
    logic busy_b, done_b, resp_b, tie_b, serr_b;
    logic [CW_A-1:0] c1_a, c2_a;
    logic [CW_B-1:0] c1_b, c2_b;

    int ro_half[NRO];
    int checks = 0;
    int errors = 0;
    bit use_b = 1'b0;
    bit last_resp, last_tie;
    logic busy_x, done_x, resp_x, tie_x, serr_x;
    logic [15:0] c1_x, c2_x;

    typedef struct {
        bit         b;
        logic [2:0] s1;
        logic [2:0] s2;
        bit         e_resp;
        bit         e_tie;
        bit         e_serr;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    // RO bank: half period in ns, 0 = stuck; all delays are multiples of 5 ns
    // plus a 1..3 ns offset so RO edges never coincide with clk edges.
    for (genvar g = 0; g < NRO; g++) begin : g_ro
        logic r;
        initial begin
            r = 1'b0;
            #(1 + (g % 3));
            forever begin
                if (ro_half[g] == 0) begin
                    #5;
                end else begin
                    #(ro_half[g]);
                    r = ~r;
                end
            end
        end
        assign ro_out[g] = r;
    end

    ro_freq_comparator #(.NUM_RO(NRO), .CNT_W(CW_A), .WINDOW(WIN_A), .SETTLE(SET)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .ro1_sel(ro1_sel), .ro2_sel(ro2_sel),
        .ro_out(ro_out), .busy(busy_a), .done(done_a), .response(resp_a), .tie(tie_a),
        .sel_err(serr_a), .count1(c1_a), .count2(c2_a));

    ro_freq_comparator #(.NUM_RO(NRO), .CNT_W(CW_B), .WINDOW(WIN_B), .SETTLE(SET)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .ro1_sel(ro1_sel), .ro2_sel(ro2_sel),
        .ro_out(ro_out), .busy(busy_b), .done(done_b), .response(resp_b), .tie(tie_b),
        .sel_err(serr_b), .count1(c1_b), .count2(c2_b));

    always_comb begin
        if (use_b) begin
            busy_x = busy_b; done_x = done_b; resp_x = resp_b; tie_x = tie_b; serr_x = serr_b;
            c1_x = 16'(c1_b); c2_x = 16'(c2_b);
        end else begin
            busy_x = busy_a; done_x = done_a; resp_x = resp_a; tie_x = tie_a; serr_x = serr_a;
            c1_x = c1_a; c2_x = c2_a;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: rising edges of a periodic signal in a window of win clk cycles
    // (10 ns each) is floor or ceil of window/period, then clipped at the max.
    task automatic exp_range(input int half, input int win, input int cw, output int lo, output int hi);
        int maxv, len;
        maxv = (1 << cw) - 1;
        len  = win * 10;
        if (half == 0) begin
            lo = 0; hi = 0;
        end else begin
            lo = len / (2 * half);
            hi = (len + 2 * half - 1) / (2 * half);
        end
        if (lo > maxv) lo = maxv;
        if (hi > maxv) hi = maxv;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done_x !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input bit b, input logic [2:0] s1, input logic [2:0] s2,
                       input bit scramble, input bit extra_start);
        int win, cw, lat, lo1, hi1, lo2, hi2, c1, c2, pulses;
        win = b ? WIN_B : WIN_A;
        cw  = b ? CW_B : CW_A;
        use_b = b;
        @(negedge clk);
        ro1_sel = s1; ro2_sel = s2;
        start_a = !b; start_b = b;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        chk("busy_on_start", busy_x, 1);
        chk("sel_err_on_start", serr_x, (s1 == s2) ? 1 : 0);
        chk("counts_cleared", {c1_x, c2_x}, 0);
        lat = 0;
        while (done_x !== 1'b1 && lat < win + SET + 20) begin
            @(negedge clk);
            lat++;
            if (scramble) begin
                ro1_sel = 3'($urandom);
                ro2_sel = 3'($urandom);
            end
            if (extra_start && lat == 10) begin
                start_a = !b; start_b = b;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
        chk("latency", lat, win + SET + 1);
        chk("busy_low_at_done", busy_x, 0);
        c1 = int'(c1_x); c2 = int'(c2_x);
        last_resp = resp_x; last_tie = tie_x;
        exp_range(ro_half[s1], win, cw, lo1, hi1);
        exp_range(ro_half[s2], win, cw, lo2, hi2);
        chk_rng("count1", c1, lo1, hi1);
        chk_rng("count2", c2, lo2, hi2);
        if (s1 == s2) begin
            chk("sel_err_counts_equal", c1, c2);
            chk("sel_err_tie", last_tie, 1);
            chk("sel_err_response", last_resp, 0);
        end else begin
            chk("tie", last_tie, (c1 == c2) ? 1 : 0);
            chk("response", last_resp, (c1 > c2) ? 1 : 0);
            if (lo1 > hi2) chk("response_model", last_resp, 1);
            else if (hi1 < lo2) chk("response_model", last_resp, 0);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_x) pulses++;
        end
        chk("single_done_pulse", pulses, 0);
    endtask

    initial begin
        int lat, pulses;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ro1_sel = 3'd0; ro2_sel = 3'd0;
        ro_half = '{30, 20, 25, 30, 0, 40, 35, 0};
        vecs[0] = '{1'b0, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'd2, 3'd2, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 3'd4, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0};

        // Reset with ROs toggling, then 100 idle cycles without start.
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outputs_a", {busy_a, done_a, resp_a, tie_a, serr_a, c1_a, c2_a}, 0);
            chk("idle_outputs_b", {busy_b, done_b, resp_b, tie_b, serr_b, c1_b, c2_b}, 0);
        end

        // Table-driven runs with fixed RO periods.
        for (int i = 0; i < 7; i++) begin
            run(vecs[i].b, vecs[i].s1, vecs[i].s2, 1'b0, 1'b0);
            chk("vec_response", last_resp, vecs[i].e_resp);
            chk("vec_tie", last_tie, vecs[i].e_tie);
            chk("vec_sel_err", serr_x, vecs[i].e_serr);
        end
        chk("sat_count1", c1_b, 15);
        chk("sat_count2", c2_b, 15);

        // Start pulse while busy is ignored.
        run(1'b0, 3'd5, 3'd3, 1'b0, 1'b1);
        chk("restart_ignored_response", last_resp, 0);

        // Start held through the done cycle: ignored there, accepted next cycle.
        use_b = 1'b0;
        @(negedge clk);
        ro1_sel = 3'd3; ro2_sel = 3'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(lat);
        chk("seq_latency", lat, WIN_A + SET + 1);
        start_a = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", busy_a, 0);
        @(negedge clk);
        start_a = 1'b0;
        chk("start_after_done_accepted", busy_a, 1);
        wait_done(lat);
        chk("seq_latency_2", lat, WIN_A + SET + 1);
        chk("seq_response", resp_a, 1);

        // Reset in the middle of COUNT.
        repeat (5) @(negedge clk);
        ro1_sel = 3'd3; ro2_sel = 3'd5; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (SET + 20) @(negedge clk);
        chk("busy_mid_run", busy_a, 1);
        reset_n = 1'b0;
        #1;
        chk("reset_busy", busy_a, 0);
        chk("reset_counts", {c1_a, c2_a}, 0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        reset_n = 1'b1;
        repeat (WIN_A + 10) begin
            @(negedge clk);
            if (done_a || busy_a) pulses++;
        end
        chk("reset_no_done", pulses, 0);
        run(1'b0, 3'd3, 3'd5, 1'b0, 1'b0);
        chk("after_reset_response", last_resp, 1);

        // Randomised RO periods, selects, and mid-run select changes.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < NRO; k++) begin
                ro_half[k] = ($urandom_range(0, 7) == 0) ? 0 : 5 * int'($urandom_range(3, 12));
            end
            repeat (30) @(negedge clk);
            run((r % 6) == 3, 3'($urandom), 3'($urandom), 1'b1, (r % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ro_freq_comparator.md
Name: ro_freq_comparator

Overview:
- Downstream consumer of the RO selector stage: takes the two ring-oscillator indices (ro1_sel, ro2_sel) and the raw outputs of the 8-RO bank.
- Counts rising edges of each selected RO over a fixed gate window of system clocks and compares the two counts.
- Emits one PUF response bit per challenge, plus the raw counts for characterisation and debug.

Parameters:
- NUM_RO, 8, number of oscillators in the bank; sel width is fixed at 3 bits.
- CNT_W, 16, width of each edge counter.
- WINDOW, 1024, gate length in clk cycles (1..2^20).
- SETTLE, 4, clk cycles discarded after start so the synchronizers flush (>=3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one comparison; ignored unless idle
- ro1_sel  in  3  index of first RO, sampled on accepted start
- ro2_sel  in  3  index of second RO, sampled on accepted start
- ro_out  in  NUM_RO  raw RO outputs, asynchronous to clk
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results are valid
- response  out  1  PUF bit: 1 if count1 > count2
- tie  out  1  count1 == count2 at end of window
- sel_err  out  1  ro1_sel == ro2_sel at accepted start
- count1  out  CNT_W  edge count of RO ro1_sel
- count2  out  CNT_W  edge count of RO ro2_sel

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - All synchronizer flops, counters, the window timer and the latched selects are cleared.
  - busy=0, done=0, response=0, tie=0, sel_err=0, count1=count2=0.
- Synchronisation:
  - Every ro_out bit passes through a 3-flop chain s1,s2,s3.
  - Edge = s2 & ~s3.
  - Selection muxes apply after synchronisation, never on raw RO nets.
  - Accurate counting requires each RO period to be >2 clk periods. Faster ROs alias; this is a documented limitation and is not detected.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE:
  - On start=1, latch sel1/sel2, clear counters and outputs (response, tie, count1/2), set sel_err=(ro1_sel==ro2_sel), busy=1, and go to SETTLE.
  - busy goes high on the edge that samples start.
- SETTLE: hold for exactly SETTLE cycles. No edges are counted. Then go to COUNT.
- COUNT:
  - Lasts exactly WINDOW cycles.
  - Each cycle, counter1 += edge[sel1] and counter2 += edge[sel2].
  - Counters saturate at 2^CNT_W-1 and never wrap.
- DONE (1 cycle):
  - done=1.
  - response = (cnt1 > cnt2) & ~sel_err.
  - tie = (cnt1 == cnt2).
  - count1/count2 hold the final counts.
  - busy drops in the same cycle; next state is IDLE.
- Latency: done is high in the cycle that begins exactly SETTLE+WINDOW+1 clk edges after the edge that sampled start.
- Result outputs (response, tie, sel_err, count1, count2) hold their values until the next accepted start.
- Boundary conditions:
  - start while busy: ignored, with no restart and no queueing.
  - start in the DONE cycle: ignored; start is accepted from the following IDLE cycle.
  - ro1_sel/ro2_sel changes during a run have no effect, because the latched values are used.
  - sel_err=1: the run still executes; count1==count2 so tie=1, and response is forced to 0.
  - Both counters saturated: tie=1, response=0.
  - reset_n asserted mid-run: immediate return to the reset state. No done pulse is produced and partial counts are discarded.
  - ro_out stuck: the corresponding count is 0.

Test Plan:
- Reset with ro_out toggling, then release with no start → busy=0, done=0, all outputs 0, and state remains idle for 100 cycles.
- WINDOW=48, SETTLE=4; RO3 period 6 clk, RO5 period 8 clk; start with sel1=3, sel2=5 → done 53 edges after start, count1=8 (±1), count2=6 (±1), response=1, tie=0.
- Same setup with sel1=5, sel2=3 → response=0 and counts swapped; then pulse start again while busy → run not restarted, done pulses once.
- sel1=sel2=2 → sel_err=1, tie=1, response=0, count1==count2.
- CNT_W=4, WINDOW=200, RO1 period 4 clk, RO0 period 6 clk → count1=count2=15 (saturated), tie=1, response=0.
- Assert reset_n low 20 cycles into COUNT → busy=0 and counts 0 immediately; no done pulse. A fresh start afterwards completes normally.
